// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result types and flag bit positions
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 4;
    localparam int REG_CNT = 8;
    localparam int REG_AW  = $clog2(REG_CNT);

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
        logic              flag_we;
        logic [REG_AW-1:0] dest;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - result push handshake and writeback bus request/grant
interface alu_writeback_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [FLAG_W-1:0] in_flags;
    logic              in_flag_we;
    logic [REG_AW-1:0] in_dest;
    logic              wb_req;
    logic              wb_grant;

    modport master (
        output in_valid, in_data, in_flags, in_flag_we, in_dest, wb_grant,
        input  in_ready, wb_req
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_flag_we, in_dest, wb_grant,
        output in_ready, wb_req
    );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - pending-result FIFO exposing its slots for operand bypass
module wb_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH)-1:0] head_ptr,
    output wb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         vld
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head     = entries[rd_ptr];
    assign head_ptr = rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            // push and pop never target the same slot: that needs empty or full
            if (pop_ok) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            entries[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - writeback stage: result buffer, register file, flags, operand bypass
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic              clk,
    input  logic              rst,
    alu_writeback_if.slave    bus,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [FLAG_W-1:0] flags_out,
    output logic [7:0]        commit_cnt
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t         in_entry;
    wb_entry_t         head;
    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] regs [REG_CNT];

    assign in_entry     = '{data: bus.in_data, flags: bus.in_flags,
                            flag_we: bus.in_flag_we, dest: bus.in_dest};
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && bus.wb_grant;
    assign bus.in_ready = !full;
    assign bus.wb_req   = !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .head_ptr   (head_ptr),
        .entries    (entries),
        .vld        (vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++)
                regs[i] <= '0;
            flags_out  <= '0;
            commit_cnt <= '0;
        end else if (pop) begin
            regs[head.dest] <= head.data;
            if (head.flag_we)
                flags_out <= head.flags;
            commit_cnt <= commit_cnt + 8'd1;
        end
    end

    // Walk oldest to youngest so the youngest matching entry overrides.
    always_comb begin
        logic [PW-1:0] idx;
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        idx       = head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (vld[idx] && entries[idx].dest == rd_addr_a)
                rd_data_a = entries[idx].data;
            if (vld[idx] && entries[idx].dest == rd_addr_b)
                rd_data_b = entries[idx].data;
        end
    end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU execute units (ADD/SUB/MUL/...). Accepts each 8-bit result with its 4-bit status flags and destination register through a valid/ready handshake. Buffers up to DEPTH results and commits them into an internal 8×8 register file and the processor flag register when the shared writeback bus is granted. Provides bypassed operand read ports back to operand fetch.

## Interface
- DATA_W, 8: result and register width
- REG_CNT, 8: number of architectural registers (address width = clog2(REG_CNT))
- FLAG_W, 4: status flag width; bit0 Z, bit1 S, bit2 C, bit3 V
- DEPTH, 2: pending-result buffer depth (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a result
- in_ready  out  1  stage can accept; high when buffer not full
- in_data  in  DATA_W  ALU result
- in_flags  in  FLAG_W  ALU status flags
- in_flag_we  in  1  1 = this result updates the flag register
- in_dest  in  3  destination register index
- wb_req  out  1  buffer non-empty, requesting the shared writeback bus
- wb_grant  in  1  bus granted this cycle; head entry commits
- rd_addr_a, rd_addr_b  in  3  operand read addresses
- rd_data_a, rd_data_b  out  DATA_W  operand data, combinational, bypassed
- flags_out  out  FLAG_W  committed flag register
- commit_cnt  out  8  number of commits, wraps 255→0

## Operation
- Push: in_valid && in_ready at an edge writes {data, flags, flag_we, dest} at buffer tail.
- Pop/commit: wb_req && wb_grant at an edge writes head data to regfile[dest]; if head flag_we, flags_out ← head flags, else flags_out unchanged; commit_cnt increments; head advances.
- wb_grant while wb_req low: ignored, no state change.
- Push and pop in same edge: both happen; count unchanged. Full buffer: in_ready low, so only pop possible.
- in_ready = (count != DEPTH); depends on registered count only, never on wb_grant or in_valid.
- Read bypass: rd_data_x = data of youngest pending buffer entry with dest == rd_addr_x; else regfile[rd_addr_x]. The entry being committed this cycle still counts as pending until the edge.
- Register 0 is an ordinary writable register.
- Two pending entries with the same dest: committed in order; the younger wins in the regfile and in bypass.
- Pointers wrap modulo DEPTH; count is a clog2(DEPTH)+1 bit counter.

## Timing
- Reset (async assert, any cycle, including mid-commit): buffer empty, in_ready=1, wb_req=0, all regfile entries 0x00, flags_out=0x0, commit_cnt=0. Pending results are discarded.
- Push latency: accepted at edge N → wb_req high and bypass visible after edge N; earliest commit at edge N+1, regfile/flags_out visible after N+1.
- Throughput: one push and one commit per cycle sustained when wb_grant held high.
- Outputs in_ready, wb_req, flags_out, and commit_cnt are registered-state-derived. rd_data_a/b are combinational from addresses and state.

## Structure
- Shared package alu_pkg: DATA_W, FLAG_W, flag bit index constants (FLAG_Z=0, FLAG_S=1, FLAG_C=2, FLAG_V=3), wb_entry_t struct {data, flags, flag_we, dest}. Execute units use the same constants.
- One sub-module: wb_fifo (DEPTH-entry FIFO of wb_entry_t with exposed entry array and valid bits for bypass search). Regfile, flag register, and bypass mux live in alu_writeback.

## Test plan
- Reset then push {0x2A, flags 0x0, flag_we=1, dest 3} with wb_grant=1 → after next edge regfile[3]=0x2A, flags_out=0x0, commit_cnt=1, wb_req=0.
- wb_grant=0, push 0xF0 →r1 and 0x10 →r2 → in_ready=0 after second push; third in_valid is not accepted. Raise grant → commits r1 then r2 in two cycles, and in_ready returns high after the first.
- Pending 0x55→r4 (uncommitted), rd_addr_a=4 → rd_data_a=0x55 while regfile[4]=0x00. Push 0x66→r4 → rd_data_a=0x66; after both commit, regfile[4]=0x66.
- Commit with flag_we=0, flags 0xF, after flags_out=0x4 → flags_out stays 0x4. Then MUL 0x10×0x10 result 0x00, flags Z|C=0x5, flag_we=1 → flags_out=0x5.
- Simultaneous push and commit at count=1 for 20 cycles → count stays 1, 20 commits in order, commit_cnt=+20. Also run 260 commits → commit_cnt wraps to 4.
- Assert rst mid-stream with 2 pending entries and wb_grant=1 → immediately wb_req=0, in_ready=1, flags_out=0, and no regfile write from the discarded entries.
